tmu_meshfetch: RTL and testbench
================================

# tmu_meshfetch

Wishbone DMA read master that fetches the vertex mesh the PFPU writes to memory and streams it to the texture-mapping pipeline. It walks the mesh in raster order and reads two 32-bit words per point (d1, d2) using the PFPU DMA address layout. Each point is delivered with its (x, y) coordinates over a stb/ack handshake. The block sits between the system Wishbone bus and the TMU geometry stage, and is started by the TMU control interface.

## Interface
Parameters: none.

- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a mesh fetch; ignored while busy
- mesh_base  in  29  mesh base address in 8-byte units; sampled on accepted start
- hmesh_last  in  7  last x index; sampled on accepted start
- vmesh_last  in  7  last y index; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the done cycle
- irq  out  1  one-cycle pulse when the last point has been accepted downstream
- wbm_adr_o  out  32  byte address
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  constant 0
- wbm_sel_o  out  4  constant 4'b1111
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge
- pipe_stb_o  out  1  output point valid
- pipe_ack_i  in  1  downstream accepts the point (transfer when stb & ack)
- x_o, y_o  out  7 each  point coordinates
- d1_o, d2_o  out  32 each  point words

## Operation
- Point (x,y) byte address A = {mesh_base,3'b000} + {y,x,3'b000}, computed modulo 2^32. d1 is read at A, d2 at A+4.
- Raster order: x runs 0..hmesh_last, then x returns to 0 and y increments. The last point is x==hmesh_last && y==vmesh_last.
- Storage: a holding register (x, y, d1, d2) and an output register. Output slot free = !pipe_stb_o || pipe_ack_i.
- FSM states:
  - IDLE: on start, latch config, clear x and y, go to FETCH0.
  - FETCH0: cyc=stb=1, adr=A. On ack, latch d1 into hold, go to FETCH1.
  - FETCH1: cyc=stb=1, adr=A+4. On ack:
    - if the slot is free this cycle, load the output register directly from hold, d2 and wbm_dat_i; go to DRAIN if this was the last point, else advance x/y and go to FETCH0;
    - otherwise latch d2 into hold and go to WAIT.
  - WAIT: cyc=stb=0. When the slot is free, move hold into the output register, then advance/go to FETCH0, or go to DRAIN if it was the last point.
  - DRAIN: cyc=stb=0. When the slot is free (last point accepted or already gone), pulse irq and go to IDLE.
- pipe_stb_o is set on an output load, cleared on pipe_ack_i without a simultaneous load, and held on a simultaneous ack and load.
- busy = (state != IDLE). A start while busy has no effect.
- Reset (async, any time, including mid bus cycle) clears state to IDLE. cyc, stb, busy, irq, pipe_stb_o, x_o, y_o, d1_o, d2_o and wbm_adr_o are all 0 immediately; pending bus data is discarded.

## Timing
- Wishbone classic: adr/cyc/stb stay stable until ack; ack is sampled on the clock edge. cyc stays high across FETCH0→FETCH1→FETCH0 with no bubble, and drops only in WAIT, DRAIN or IDLE.
- Zero-wait slave, free downstream: start sampled at cycle 0. Word 0 at cycle 1, word 1 at cycle 2, pipe_stb_o at cycle 3. The next point's word 0 is also at cycle 3, for a sustained rate of 1 point per 2 cycles.
- Last point: irq fires in the cycle after the last handshake, or the cycle after entering DRAIN if the output is already empty. busy drops with irq.
- Output hold: pipe_stb_o and its data stay stable until pipe_ack_i.
- Backpressure: at most 2 points are buffered (output and hold). The bus is then idle.

## Test plan
- Single point: mesh_base=29'h0200_0000, hmesh_last=vmesh_last=0, zero-wait slave returning 32'h3F80_0000 then 32'h4000_0000, pipe_ack_i=1.
  - Expect reads at 0x1000_0000 and 0x1000_0004.
  - Expect one output with x=0, y=0, d1=3F80_0000, d2=4000_0000.
  - irq pulses once; busy is high for 4 cycles.
- 2x2 mesh (hmesh_last=vmesh_last=1, base 0): d1 addresses 0x000, 0x008, 0x400, 0x408. Outputs in order (0,0), (1,0), (0,1), (1,1).
- Wait states: slave acks 3 cycles after each stb. adr/stb stay constant while waiting, and data matches the value presented with ack.
- Backpressure: 4x1 mesh, pipe_ack_i low for 20 cycles.
  - Exactly 2 points are fetched, then cyc stays low.
  - On release, all 4 points arrive in order with no loss or duplication, then irq.
- Address wrap: mesh_base=29'h1FFF_FFFF, hmesh_last=1. Reads at FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Control edge cases:
  - A start pulsed during busy changes nothing.
  - sys_rst asserted while stb is high and ack is pending drops cyc/stb/busy/pipe_stb_o without waiting for a clock.
  - After reset, a new start fetches correctly from (0,0).

Source files
------------

// File: rtl/tmu_meshfetch.sv
// Purpose : Wishbone read master that walks the PFPU vertex mesh in raster order and streams (x,y,d1,d2) points.
// Latency : start -> first point valid 3 cycles with a zero-wait slave; sustained 1 point per 2 bus cycles.
// Backpressure: at most two points buffered (output + hold); bus goes idle until the output slot frees.
//
// Ports:
//   sys_clk/sys_rst            clock, async active-high reset
//   start, mesh_base, hmesh_last, vmesh_last   control; config sampled on an accepted start
//   busy, irq                  status; irq pulses once the last point has been taken downstream
//   wbm_*                      Wishbone classic read master (we=0, sel=1111)
//   pipe_stb_o/pipe_ack_i      point handshake; x_o, y_o, d1_o, d2_o carry the point
module tmu_meshfetch (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [28:0] mesh_base,
    input  logic [6:0]  hmesh_last,
    input  logic [6:0]  vmesh_last,
    output logic        busy,
    output logic        irq,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        pipe_stb_o,
    input  logic        pipe_ack_i,
    output logic [6:0]  x_o,
    output logic [6:0]  y_o,
    output logic [31:0] d1_o,
    output logic [31:0] d2_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [28:0] base_q, base_d;
    logic [6:0]  hlast_q, hlast_d;
    logic [6:0]  vlast_q, vlast_d;
    logic [6:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [31:0] hold_d1_q, hold_d1_d;
    logic [31:0] hold_d2_q, hold_d2_d;
    logic [6:0]  out_x_q, out_x_d;
    logic [6:0]  out_y_q, out_y_d;
    logic [31:0] out_d1_q, out_d1_d;
    logic [31:0] out_d2_q, out_d2_d;
    logic        out_stb_q, out_stb_d;

    logic        slot_free;
    logic        last_pt;
    logic        load;
    logic [31:0] pt_adr;

    // The point being fetched is always (x_q, y_q); x/y only advance once that
    // point has moved into the output register, so hold needs no coordinates.
    assign pt_adr    = {base_q, 3'b000} + {15'd0, y_q, x_q, 3'b000};
    assign slot_free = !out_stb_q || pipe_ack_i;
    assign last_pt   = (x_q == hlast_q) && (y_q == vlast_q);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        hlast_d   = hlast_q;
        vlast_d   = vlast_q;
        x_d       = x_q;
        y_d       = y_q;
        hold_d1_d = hold_d1_q;
        hold_d2_d = hold_d2_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_d1_d  = out_d1_q;
        out_d2_d  = out_d2_q;
        out_stb_d = out_stb_q;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = mesh_base;
                    hlast_d = hmesh_last;
                    vlast_d = vmesh_last;
                    x_d     = 7'd0;
                    y_d     = 7'd0;
                    state_d = S_FETCH0;
                end
            end
            S_FETCH0: begin
                if (wbm_ack_i) begin
                    hold_d1_d = wbm_dat_i;
                    state_d   = S_FETCH1;
                end
            end
            S_FETCH1: begin
                if (wbm_ack_i) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        out_d2_d = wbm_dat_i;
                    end else begin
                        hold_d2_d = wbm_dat_i;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (slot_free) begin
                    load     = 1'b1;
                    out_d2_d = hold_d2_q;
                end
            end
            S_DRAIN: begin
                // DRAIN is only entered right after loading the last point, so an
                // empty output register means that point has been taken.
                if (!out_stb_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            out_x_d   = x_q;
            out_y_d   = y_q;
            out_d1_d  = hold_d1_q;
            out_stb_d = 1'b1;
            if (last_pt) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_FETCH0;
                if (x_q == hlast_q) begin
                    x_d = 7'd0;
                    y_d = y_q + 7'd1;
                end else begin
                    x_d = x_q + 7'd1;
                end
            end
        end else if (pipe_ack_i) begin
            out_stb_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            base_q    <= 29'd0;
            hlast_q   <= 7'd0;
            vlast_q   <= 7'd0;
            x_q       <= 7'd0;
            y_q       <= 7'd0;
            hold_d1_q <= 32'd0;
            hold_d2_q <= 32'd0;
            out_x_q   <= 7'd0;
            out_y_q   <= 7'd0;
            out_d1_q  <= 32'd0;
            out_d2_q  <= 32'd0;
            out_stb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            hlast_q   <= hlast_d;
            vlast_q   <= vlast_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hold_d1_q <= hold_d1_d;
            hold_d2_q <= hold_d2_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_d1_q  <= out_d1_d;
            out_d2_q  <= out_d2_d;
            out_stb_q <= out_stb_d;
        end
    end

    // Bus signals decode straight from state so reset drops them without a clock.
    always_comb begin
        wbm_adr_o = 32'd0;
        case (state_q)
            S_FETCH0: wbm_adr_o = pt_adr;
            S_FETCH1: wbm_adr_o = pt_adr + 32'd4;
            default:  wbm_adr_o = 32'd0;
        endcase
    end

    assign wbm_cyc_o  = (state_q == S_FETCH0) || (state_q == S_FETCH1);
    assign wbm_stb_o  = wbm_cyc_o;
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 4'b1111;
    assign busy       = (state_q != S_IDLE);
    assign irq        = (state_q == S_DRAIN) && !out_stb_q;
    assign pipe_stb_o = out_stb_q;
    assign x_o        = out_x_q;
    assign y_o        = out_y_q;
    assign d1_o       = out_d1_q;
    assign d2_o       = out_d2_q;

endmodule

// File: tb/tb_tmu_meshfetch.sv
// Purpose : directed, table-driven bench for tmu_meshfetch with a Wishbone slave model and output monitor.
// Latency : n/a (bench).
// Backpressure: pipe_ack_i driven per vector; slave wait states per vector.
module tb_tmu_meshfetch;

    logic        sys_clk;
    logic        sys_rst;
    logic        start;
    logic [28:0] mesh_base;
    logic [6:0]  hmesh_last;
    logic [6:0]  vmesh_last;
    logic        busy;
    logic        irq;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        pipe_stb_o;
    logic        pipe_ack_i;
    logic [6:0]  x_o;
    logic [6:0]  y_o;
    logic [31:0] d1_o;
    logic [31:0] d2_o;

    tmu_meshfetch dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .mesh_base  (mesh_base),
        .hmesh_last (hmesh_last),
        .vmesh_last (vmesh_last),
        .busy       (busy),
        .irq        (irq),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .pipe_stb_o (pipe_stb_o),
        .pipe_ack_i (pipe_ack_i),
        .x_o        (x_o),
        .y_o        (y_o),
        .d1_o       (d1_o),
        .d2_o       (d2_o)
    );

    typedef struct packed {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [31:0] d1;
        logic [31:0] d2;
    } pt_t;

    typedef struct {
        logic [28:0]       base;
        logic [6:0]        hl;
        logic [6:0]        vl;
        int                ws;
        int                bp;
        bit                poke;
        int                npts;
        logic [0:7][31:0]  ea;   // expected read addresses, in bus order
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ws = 0;
    int          wcnt = 0;
    int          busy_cnt = 0;
    int          irq_cnt = 0;
    int          stab_err = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_adr = 32'd0;
    logic [31:0] rd_q[$];
    pt_t         out_q[$];
    vec_t        vt[6];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Slave memory contents: two fixed words for the single-point case, otherwise address-derived.
    function automatic logic [31:0] fdat(input logic [31:0] a);
        if (a == 32'h1000_0000) return 32'h3F80_0000;
        if (a == 32'h1000_0004) return 32'h4000_0000;
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Wishbone slave: acks ws cycles after stb first appears, data presented with ack.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (wbm_cyc_o && wbm_stb_o && !sys_rst) begin
                if (wcnt >= ws) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = fdat(wbm_adr_o);
                    wcnt = 0;
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                wbm_ack_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitors sample mid-cycle: bus reads, output handshakes, busy/irq, address stability while waiting.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) rd_q.push_back(wbm_adr_o);
            if (pipe_stb_o && pipe_ack_i) out_q.push_back('{x: x_o, y: y_o, d1: d1_o, d2: d2_o});
            if (busy) busy_cnt++;
            if (irq) irq_cnt++;
            if (prev_pend && wbm_stb_o && (wbm_adr_o != prev_adr)) stab_err++;
            if (prev_pend && !wbm_stb_o) stab_err++;
            prev_pend = wbm_stb_o && !wbm_ack_i;
            prev_adr  = wbm_adr_o;
        end else begin
            prev_pend = 1'b0;
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        bit   seen;
        int   nr;
        logic [6:0] ex;
        logic [6:0] ey;
        rd_q.delete();
        out_q.delete();
        busy_cnt = 0;
        irq_cnt  = 0;
        stab_err = 0;
        ws = v.ws;
        pipe_ack_i = (v.bp == 0);
        @(posedge sys_clk); #1;
        start = 1'b1;
        mesh_base = v.base;
        hmesh_last = v.hl;
        vmesh_last = v.vl;
        @(posedge sys_clk); #1;
        start = 1'b0;
        // Config is sampled only at start; scramble it afterwards.
        mesh_base = 29'h0AAA_AAAA;
        hmesh_last = 7'h55;
        vmesh_last = 7'h2A;
        if (v.poke) begin
            @(posedge sys_clk); #1;
            start = 1'b1;
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        if (v.bp > 0) begin
            repeat (v.bp) @(posedge sys_clk);
            @(negedge sys_clk);
            chk({tag, " bp_reads"}, 32'(rd_q.size()), 32'd4);
            chk({tag, " bp_cyc"}, 32'(wbm_cyc_o), 32'd0);
            chk({tag, " bp_stb"}, 32'(pipe_stb_o), 32'd1);
            chk({tag, " bp_hold_x"}, 32'(x_o), 32'd0);
            chk({tag, " bp_hold_d1"}, d1_o, fdat(v.ea[0]));
            chk({tag, " bp_hold_d2"}, d2_o, fdat(v.ea[1]));
            @(posedge sys_clk); #1;
            pipe_ack_i = 1'b1;
        end
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            if (irq) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " irq_timeout"}, 32'(seen), 32'd1);
        repeat (3) @(negedge sys_clk);
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        chk({tag, " n_reads"}, 32'(rd_q.size()), 32'(2 * v.npts));
        nr = (rd_q.size() < 8) ? rd_q.size() : 8;
        for (int i = 0; i < nr; i++) chk({tag, " rd_adr"}, rd_q[i], v.ea[i]);
        chk({tag, " n_out"}, 32'(out_q.size()), 32'(v.npts));
        ex = 7'd0;
        ey = 7'd0;
        for (int i = 0; i < out_q.size(); i++) begin
            chk({tag, " out_x"}, 32'(out_q[i].x), 32'(ex));
            chk({tag, " out_y"}, 32'(out_q[i].y), 32'(ey));
            if (i < 4) begin
                chk({tag, " out_d1"}, out_q[i].d1, fdat(v.ea[2 * i]));
                chk({tag, " out_d2"}, out_q[i].d2, fdat(v.ea[2 * i + 1]));
            end
            if (ex == v.hl) begin
                ex = 7'd0;
                ey = ey + 7'd1;
            end else begin
                ex = ex + 7'd1;
            end
        end
        chk({tag, " irq_cnt"}, 32'(irq_cnt), 32'd1);
        chk({tag, " adr_stable"}, 32'(stab_err), 32'd0);
        if (v.npts == 1) chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    endtask

    initial begin
        bit hit;
        vt[0] = '{base: 29'h0200_0000, hl: 7'd0, vl: 7'd0, ws: 0, bp: 0, poke: 1'b0, npts: 1,
                  ea: {32'h1000_0000, 32'h1000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
        vt[1] = '{base: 29'h0, hl: 7'd1, vl: 7'd1, ws: 0, bp: 0, poke: 1'b0, npts: 4,
                  ea: {32'h000, 32'h004, 32'h008, 32'h00C, 32'h400, 32'h404, 32'h408, 32'h40C}};
        vt[2] = '{base: 29'h100, hl: 7'd1, vl: 7'd0, ws: 3, bp: 0, poke: 1'b0, npts: 2,
                  ea: {32'h800, 32'h804, 32'h808, 32'h80C, 32'h0, 32'h0, 32'h0, 32'h0}};
        vt[3] = '{base: 29'h10, hl: 7'd3, vl: 7'd0, ws: 0, bp: 20, poke: 1'b0, npts: 4,
                  ea: {32'h080, 32'h084, 32'h088, 32'h08C, 32'h090, 32'h094, 32'h098, 32'h09C}};
        vt[4] = '{base: 29'h1FFF_FFFF, hl: 7'd1, vl: 7'd0, ws: 0, bp: 0, poke: 1'b0, npts: 2,
                  ea: {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0}};
        vt[5] = '{base: 29'h20, hl: 7'd1, vl: 7'd0, ws: 0, bp: 0, poke: 1'b1, npts: 2,
                  ea: {32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0, 32'h0, 32'h0}};

        sys_rst = 1'b1;
        start = 1'b0;
        mesh_base = 29'd0;
        hmesh_last = 7'd0;
        vmesh_last = 7'd0;
        pipe_ack_i = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst stb", 32'(wbm_stb_o), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        chk("rst pipe_stb", 32'(pipe_stb_o), 32'd0);
        chk("rst adr", wbm_adr_o, 32'd0);
        chk("we", 32'(wbm_we_o), 32'd0);
        chk("sel", 32'(wbm_sel_o), 32'hF);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset while a read is pending and a point sits in the output register.
        ws = 3;
        pipe_ack_i = 1'b0;
        @(posedge sys_clk); #1;
        start = 1'b1;
        mesh_base = 29'h10;
        hmesh_last = 7'd3;
        vmesh_last = 7'd0;
        @(posedge sys_clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sys_clk);
            if (wbm_stb_o && !wbm_ack_i && pipe_stb_o) begin
                hit = 1'b1;
                break;
            end
        end
        chk("midrst setup", 32'(hit), 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("midrst cyc", 32'(wbm_cyc_o), 32'd0);
        chk("midrst stb", 32'(wbm_stb_o), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst pipe_stb", 32'(pipe_stb_o), 32'd0);
        chk("midrst adr", wbm_adr_o, 32'd0);
        chk("midrst d1", d1_o, 32'd0);
        #2 sys_rst = 1'b0;

        run_vec(vt[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
